// File: rtl/alu_serial_driver_pkg.sv
// Shared opcode and FSM-state definitions for the bit-serial ALU slice driver.
`default_nettype none

package alu_serial_driver_pkg;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_serial_driver.sv
// Drives an external 1-bit ALU slice LSB-first over WIDTH cycles, carries between
// bits and returns the assembled result over a valid/ready response port.
`default_nettype none

module alu_serial_driver
  import alu_serial_driver_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [1:0]       alu_op,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  input  logic             alu_out,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

  // Operands shift right each RUN cycle so the current bit is always at [0].
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d = {alu_out, res_q[WIDTH-1:1]};
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        if (op_q == ALU_ADD) carry_d = alu_cout;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The slice is held quiet outside RUN.
  always_comb begin
    cmd_ready  = (state_q == ST_IDLE);
    rsp_valid  = (state_q == ST_DONE);
    rsp_result = res_q;
    rsp_carry  = carry_q;
    alu_op     = 2'b00;
    alu_a      = 1'b0;
    alu_b      = 1'b0;
    alu_cin    = 1'b0;
    if (state_q == ST_RUN) begin
      alu_op  = op_q;
      alu_a   = a_q[0];
      alu_b   = b_q[0];
      alu_cin = (op_q == ALU_ADD) ? carry_q : 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_serial_driver.sv
// Self-checking bench: driver paired with a behavioural 1-bit slice; vectors,
// corner sequences and randomized ops against an arithmetic reference.
`default_nettype none

module tb_alu_serial_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic [1:0] alu_op;
  logic       alu_a, alu_b, alu_cin;
  logic       alu_out, alu_cout;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  alu_serial_driver #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry)
  );

  // Behavioural 1-bit slice
  always_comb begin
    alu_out  = 1'b0;
    alu_cout = 1'b0;
    case (alu_op)
      2'b00: alu_out = alu_a & alu_b;
      2'b01: alu_out = alu_a | alu_b;
      2'b10: alu_out = alu_a ^ alu_b;
      default: {alu_cout, alu_out} = 2'(alu_a) + 2'(alu_b) + 2'(alu_cin);
    endcase
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic, no bit-serial modelling.
  function automatic logic [8:0] ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return {1'b0, a & b};
      2'b01:   return {1'b0, a | b};
      2'b10:   return {1'b0, a ^ b};
      default: return 9'(a) + 9'(b);
    endcase
  endfunction

  // Entered and left on a negedge. lat = edges from accept edge (counted as 1)
  // up to the edge after which rsp_valid is first seen.
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int hold, input logic early_rdy,
                        output logic [7:0] res, output logic c, output int lat,
                        output int acc_cyc, output int hs_cyc);
    int n;
    logic cin_bad, rdy_bad, stable_bad;
    logic [7:0] res0;
    logic c0;
    res = 'x; c = 1'bx; lat = 0; acc_cyc = 0; hs_cyc = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      check("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    cmd_a = 8'h00; cmd_b = 8'h00;
    rsp_ready = early_rdy;
    lat = 1; cin_bad = 1'b0; rdy_bad = 1'b0;
    while (!rsp_valid && lat < 50) begin
      if (op != 2'b11 && alu_cin) cin_bad = 1'b1;
      if (cmd_ready) rdy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("cin_zero_logic_op", 32'(cin_bad), 32'd0);
    check("cmd_ready_low_run", 32'(rdy_bad), 32'd0);
    if (!rsp_valid) begin
      check("rsp_timeout", 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b0;
      return;
    end
    check("alu_quiet_done", {28'd0, alu_op, alu_a, alu_b | alu_cin}, 32'd0);
    rsp_ready = 1'b0;
    res0 = rsp_result; c0 = rsp_carry;
    stable_bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin cmd_op = 2'b11; cmd_a = 8'h55; cmd_b = 8'hAA; cmd_valid = 1'b1; end
      if (h == 2) cmd_valid = 1'b0;
      @(negedge clk);
      if (rsp_result !== res0 || rsp_carry !== c0 || !rsp_valid || cmd_ready) stable_bad = 1'b1;
    end
    cmd_valid = 1'b0;
    if (hold > 0) check("backpressure_stable", 32'(stable_bad), 32'd0);
    res = rsp_result; c = rsp_carry;
    rsp_ready = 1'b1;
    @(negedge clk);
    hs_cyc = cyc;
    rsp_ready = 1'b0;
    check("post_hs_valid", 32'(rsp_valid), 32'd0);
    check("post_hs_ready", 32'(cmd_ready), 32'd1);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         hold;
    logic [7:0] exp_res;
    logic       exp_c;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] r;
    logic c;
    int lat, acc, hs, acc2, hs2, n;
    logic [8:0] m;
    logic [1:0] rop;
    logic [7:0] ra, rb;
    logic seen;

    vecs[0] = '{2'b11, 8'hFF, 8'h01, 0, 8'h00, 1'b1};
    vecs[1] = '{2'b00, 8'hF0, 8'h3C, 0, 8'h30, 1'b0};
    vecs[2] = '{2'b01, 8'hF0, 8'h3C, 0, 8'hFC, 1'b0};
    vecs[3] = '{2'b10, 8'hF0, 8'h3C, 0, 8'hCC, 1'b0};
    vecs[4] = '{2'b11, 8'h05, 8'h03, 5, 8'h08, 1'b0};
    vecs[5] = '{2'b11, 8'h7F, 8'h01, 0, 8'h80, 1'b0};
    vecs[6] = '{2'b10, 8'hA5, 8'hFF, 2, 8'h5A, 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = 8'h00; cmd_b = 8'h00;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_carry", 32'(rsp_carry), 32'd0);
    check("rst_alu", {28'd0, alu_op, alu_a, alu_b | alu_cin}, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold, 1'b0, r, c, lat, acc, hs);
      check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].exp_res));
      check($sformatf("vec%0d_carry", i), 32'(c), 32'(vecs[i].exp_c));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
    end

    // Back-to-back: second command presented straight after the handshake.
    run_op(2'b11, 8'h12, 8'h34, 0, 1'b0, r, c, lat, acc, hs);
    check("b2b_first_result", 32'(r), 32'h46);
    check("b2b_first_carry", 32'(c), 32'd0);
    run_op(2'b11, 8'h80, 8'h80, 0, 1'b0, r, c, lat, acc2, hs2);
    check("b2b_second_result", 32'(r), 32'h00);
    check("b2b_second_carry", 32'(c), 32'd1);
    check("b2b_accept_gap", 32'(acc2 - hs), 32'd1);

    // Reset during RUN bit 4.
    cmd_op = 2'b11; cmd_a = 8'h0F; cmd_b = 8'h0F; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun_is_running", 32'(cmd_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_alu_op", 32'(alu_op), 32'd0);
    seen = 1'b0;
    for (n = 0; n < 12; n++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("midrst_no_response", 32'(seen), 32'd0);
    run_op(2'b11, 8'h01, 8'h01, 0, 1'b0, r, c, lat, acc, hs);
    check("after_rst_result", 32'(r), 32'h02);
    check("after_rst_carry", 32'(c), 32'd0);

    // Randomized ops against the arithmetic reference.
    for (int k = 0; k < 200; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      m   = ref_op(rop, ra, rb);
      run_op(rop, ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), r, c, lat, acc, hs);
      check($sformatf("rand%0d_result op=%0d a=%0h b=%0h", k, rop, ra, rb), 32'(r), 32'(m[7:0]));
      check($sformatf("rand%0d_carry", k), 32'(c), 32'(m[8]));
      check($sformatf("rand%0d_latency", k), 32'(lat), 32'd9);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
